// File: rtl/io_responder.sv
// io_responder: peripheral end of the CPU IO port (button-gated input capture, BCD output display)
//
// Ports:
//   clock, reset          single clock, asynchronous active-high reset
//   ioControl[1:0]        01 = input request, 10 = output request, 00/11 = none
//   dadosEscrita[31:0]    value to display on an output request
//   botaoIN               one-cycle button pulse that completes an input request
//   entradaDeDados        board switches, captured on the button pulse
//   dadosLidos[31:0]      last captured switch value, zero-extended
//   pausa                 high while waiting for the button (halts the CPU)
//   busy                  high while a BCD conversion is running
//   inValid / outDone     one-cycle completion pulses for input / output
//   overflow              last output value was saturated to 999
//   unidade/dezena/centena BCD digits for the seven-segment decoders
module io_responder #(
  parameter int IN_WIDTH = 4,
  parameter int OUT_BITS = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          ioControl,
  input  logic [31:0]         dadosEscrita,
  input  logic                botaoIN,
  input  logic [IN_WIDTH-1:0] entradaDeDados,
  output logic [31:0]         dadosLidos,
  output logic                pausa,
  output logic                busy,
  output logic                inValid,
  output logic                outDone,
  output logic                overflow,
  output logic [3:0]          unidade,
  output logic [3:0]          dezena,
  output logic [3:0]          centena
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_IN = 2'd1;
  localparam logic [1:0] CONVERT = 2'd2;
  localparam int CW = $clog2(OUT_BITS + 1);
  localparam logic [OUT_BITS-1:0] MAX_V = OUT_BITS'(999);

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [11:0]         bcd_q, bcd_d;
  logic [OUT_BITS-1:0] v_q, v_d;
  logic [31:0]         dl_q, dl_d;
  logic                inv_q, inv_d;
  logic                od_q, od_d;
  logic                ov_q, ov_d;
  logic [11:0]         dig_q, dig_d;
  logic [OUT_BITS-1:0] raw;
  logic [11+OUT_BITS:0] sh;
  logic                unused_hi;

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++)
      r[4*i+:4] = b[4*i+:4] >= 4'd5 ? b[4*i+:4] + 4'd3 : b[4*i+:4];
    return r;
  endfunction

  assign raw       = dadosEscrita[OUT_BITS-1:0];
  assign unused_hi = ^dadosEscrita[31:OUT_BITS];
  // one double-dabble step: correct every nibble, then shift the whole {bcd, v} pair
  assign sh        = {add3(bcd_q), v_q} << 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    v_d     = v_q;
    dl_d    = dl_q;
    inv_d   = 1'b0;
    od_d    = 1'b0;
    ov_d    = ov_q;
    dig_d   = dig_q;
    case (state_q)
      IDLE: begin
        if (ioControl == 2'b01) begin
          state_d = WAIT_IN;
        end else if (ioControl == 2'b10) begin
          v_d     = raw > MAX_V ? MAX_V : raw;
          ov_d    = raw > MAX_V;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      WAIT_IN: begin
        if (botaoIN) begin
          dl_d    = 32'(entradaDeDados);
          inv_d   = 1'b1;
          state_d = IDLE;
        end
      end
      CONVERT: begin
        // counter past the last shift marks the commit cycle, so the digits
        // change in one step and never show a half-converted value
        if (cnt_q == CW'(OUT_BITS)) begin
          dig_d   = bcd_q;
          od_d    = 1'b1;
          state_d = IDLE;
        end else begin
          {bcd_d, v_d} = sh;
          cnt_d        = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      v_q     <= '0;
      dl_q    <= '0;
      inv_q   <= 1'b0;
      od_q    <= 1'b0;
      ov_q    <= 1'b0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      v_q     <= v_d;
      dl_q    <= dl_d;
      inv_q   <= inv_d;
      od_q    <= od_d;
      ov_q    <= ov_d;
      dig_q   <= dig_d;
    end
  end

  assign dadosLidos = dl_q;
  assign pausa      = state_q == WAIT_IN;
  assign busy       = state_q == CONVERT;
  assign inValid    = inv_q;
  assign outDone    = od_q;
  assign overflow   = ov_q;
  assign centena    = dig_q[11:8];
  assign dezena     = dig_q[7:4];
  assign unidade    = dig_q[3:0];
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: self-checking bench for io_responder
module tb_io_responder;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  ioControl = 2'b00;
  logic [31:0] dadosEscrita = '0;
  logic        botaoIN = 1'b0;
  logic [3:0]  entradaDeDados = '0;
  logic [31:0] dadosLidos;
  logic        pausa, busy, inValid, outDone, overflow;
  logic [3:0]  unidade, dezena, centena;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [3:0] c, d, u; logic ov; } exp_t;
  typedef struct { logic [31:0] data; exp_t e; } vec_t;
  exp_t sbq[$];

  io_responder dut (
    .clock(clock), .reset(reset), .ioControl(ioControl), .dadosEscrita(dadosEscrita),
    .botaoIN(botaoIN), .entradaDeDados(entradaDeDados), .dadosLidos(dadosLidos),
    .pausa(pausa), .busy(busy), .inValid(inValid), .outDone(outDone), .overflow(overflow),
    .unidade(unidade), .dezena(dezena), .centena(centena)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_out(input logic [31:0] data, input exp_t e);
    ioControl    = 2'b10;
    dadosEscrita = data;
    sbq.push_back(e);
    @(negedge clock);
    ioControl = 2'b00;
  endtask

  task automatic wait_done(input int exp_busy);
    int  busy_n = 0;
    bit  got = 0;
    exp_t e;
    for (int k = 0; k < 40 && !got; k++) begin
      if (outDone) got = 1;
      else begin
        if (busy) busy_n++;
        @(negedge clock);
      end
    end
    checks++;
    if (!got || sbq.size() == 0) begin
      errors++;
      $display("FAIL out_timeout: got no outDone expected outDone within 40 cycles");
    end else begin
      e = sbq.pop_front();
      chk("busy_cycles", busy_n, exp_busy);
      chk("digits", {centena, dezena, unidade}, {e.c, e.d, e.u});
      chk("overflow", overflow, e.ov);
      chk("busy_at_done", busy, 0);
    end
  endtask

  initial begin
    vec_t tbl[8];
    int seen;
    tbl[0] = '{32'd237,        '{4'd2, 4'd3, 4'd7, 1'b0}};
    tbl[1] = '{32'd1023,       '{4'd9, 4'd9, 4'd9, 1'b1}};
    tbl[2] = '{32'hFFFF0005,   '{4'd0, 4'd0, 4'd5, 1'b0}};
    tbl[3] = '{32'd999,        '{4'd9, 4'd9, 4'd9, 1'b0}};
    tbl[4] = '{32'd1000,       '{4'd9, 4'd9, 4'd9, 1'b1}};
    tbl[5] = '{32'd512,        '{4'd5, 4'd1, 4'd2, 1'b0}};
    tbl[6] = '{32'd0,          '{4'd0, 4'd0, 4'd0, 1'b0}};
    tbl[7] = '{32'd100,        '{4'd1, 4'd0, 4'd0, 1'b0}};

    repeat (2) @(negedge clock);
    chk("reset_state", {dadosLidos, pausa, busy, inValid, outDone, overflow, centena, dezena, unidade}, 0);
    reset = 1'b0;

    ioControl = 2'b11;
    @(negedge clock);
    ioControl = 2'b00;
    chk("noop_11", {pausa, busy}, 0);

    ioControl = 2'b01;
    @(negedge clock);
    ioControl = 2'b00;
    for (int i = 0; i < 5; i++) begin
      chk("pausa_wait", pausa, 1);
      chk("invalid_wait", inValid, 0);
      if (i < 4) @(negedge clock);
    end
    entradaDeDados = 4'hA;
    botaoIN = 1'b1;
    @(negedge clock);
    botaoIN = 1'b0;
    chk("dados_lidos", dadosLidos, 32'h0000000A);
    chk("pausa_release", pausa, 0);
    chk("invalid_pulse", inValid, 1);
    @(negedge clock);
    chk("invalid_single", inValid, 0);

    entradaDeDados = 4'h5;
    botaoIN = 1'b1;
    @(negedge clock);
    botaoIN = 1'b0;
    chk("btn_idle_ignored", dadosLidos, 32'h0000000A);
    chk("btn_idle_noinvalid", inValid, 0);

    foreach (tbl[i]) begin
      start_out(tbl[i].data, tbl[i].e);
      wait_done(11);
      @(negedge clock);
      chk("outdone_single", outDone, 0);
    end

    ioControl = 2'b01;
    botaoIN = 1'b1;
    entradaDeDados = 4'h7;
    @(negedge clock);
    ioControl = 2'b00;
    botaoIN = 1'b0;
    chk("coincident_pausa", pausa, 1);
    chk("coincident_nocapture", dadosLidos, 32'h0000000A);
    ioControl = 2'b10;
    dadosEscrita = 32'd123;
    @(negedge clock);
    ioControl = 2'b00;
    chk("out_in_wait_busy", busy, 0);
    chk("out_in_wait_pausa", pausa, 1);
    entradaDeDados = 4'h3;
    botaoIN = 1'b1;
    @(negedge clock);
    botaoIN = 1'b0;
    chk("capture_after_ignore", dadosLidos, 32'h00000003);
    seen = 0;
    repeat (15) begin
      @(negedge clock);
      if (outDone || busy) seen++;
    end
    chk("no_stray_conversion", seen, 0);
    chk("digits_held", {centena, dezena, unidade}, 12'h100);

    start_out(32'd45, '{4'd0, 4'd4, 4'd5, 1'b0});
    ioControl = 2'b01;
    @(negedge clock);
    ioControl = 2'b00;
    chk("in_during_convert", pausa, 0);
    wait_done(10);
    @(negedge clock);
    chk("pausa_after_convert", pausa, 0);

    start_out(32'd999, '{4'd9, 4'd9, 4'd9, 1'b0});
    wait_done(11);
    start_out(32'd0, '{4'd0, 4'd0, 4'd0, 1'b0});
    chk("b2b_accepted", busy, 1);
    wait_done(11);

    start_out(32'd555, '{4'd5, 4'd5, 4'd5, 1'b0});
    wait_done(11);
    @(negedge clock);
    start_out(32'd555, '{4'd5, 4'd5, 4'd5, 1'b0});
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1 chk("async_reset", {dadosLidos, pausa, busy, inValid, outDone, overflow, centena, dezena, unidade}, 0);
    sbq.delete();
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clock);
      if (outDone || busy || pausa) seen++;
    end
    chk("no_pulse_after_reset", seen, 0);
    chk("digits_after_reset", {centena, dezena, unidade}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
